lut_out_drain: RTL and testbench

// - Write-back stage directly downstream of the LUT execute controller. Once a tile's

---
 rtl/lut_out_drain.sv | 129 ++++++++++++
 tb/tb_lut_out_drain.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_out_drain.sv
// Output-buffer write-back drain: walks K x HW words (k-major) and streams them over
// valid/ready through a 2-entry credit-controlled skid FIFO that hides the 1-cycle read latency.
`ifndef HW_BS_OUT_BUF_DEPTH
`define HW_BS_OUT_BUF_DEPTH 16
`endif

module lut_out_drain #(
  parameter int unsigned BS_OUT_BUF_DEPTH = `HW_BS_OUT_BUF_DEPTH,
  parameter int unsigned OUT_DATA_W       = 512
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bs_wb_tile_start,
  input  logic [7:0]                  bs_subtile_K,
  input  logic [7:0]                  bs_subtile_HW,
  output logic [BS_OUT_BUF_DEPTH-1:0] bs_out_buf_wb_addr,
  output logic                        bs_out_buf_wb_rd,
  input  logic [OUT_DATA_W-1:0]       bs_out_buf_wb_data,
  output logic [OUT_DATA_W-1:0]       m_data,
  output logic                        m_valid,
  output logic                        m_last,
  input  logic                        m_ready,
  output logic                        bs_wb_busy,
  output logic                        bs_wb_tile_end,
  output logic                        bs_wb_start_err
);

  // Counter width: wide enough for K*HW and for the address bus.
  localparam int unsigned CW = (BS_OUT_BUF_DEPTH > 16) ? BS_OUT_BUF_DEPTH : 16;

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  typedef struct packed {
    logic                  last;
    logic [OUT_DATA_W-1:0] data;
  } word_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  total_q;
  logic [CW-1:0]  rd_cnt_q;
  logic           inflight_q;
  logic           inflight_last_q;
  word_t          fifo_q [2];
  logic           wr_ptr_q;
  logic           rd_ptr_q;
  logic [1:0]     count_q;
  logic           start_err_q;

  logic           rd_c;
  logic           last_rd_c;
  logic           pop_c;
  logic           credit_ok_c;
  logic           accept_c;
  logic           empty_size_c;
  word_t          head_c;

  assign head_c       = fifo_q[rd_ptr_q];
  assign pop_c        = (count_q != 2'd0) && m_ready;
  assign last_rd_c    = (rd_cnt_q == total_q - CW'(1));
  assign accept_c     = bs_wb_tile_start && (state == IDLE);
  assign empty_size_c = (bs_subtile_K == 8'd0) || (bs_subtile_HW == 8'd0);

  // Credit counts occupancy net of this cycle's pop so a full-rate stream reads every cycle.
  assign credit_ok_c  = (3'(count_q) + 3'(inflight_q)) <= (3'd1 + 3'(pop_c));

  // Next-state and read-issue logic
  always_comb begin
    state_nxt = state;
    rd_c      = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) state_nxt = empty_size_c ? DONE : READ;
      end
      READ: begin
        rd_c = credit_ok_c;
        if (credit_ok_c && last_rd_c) state_nxt = FLUSH;
      end
      FLUSH: begin
        if (pop_c && head_c.last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, counters and FIFO pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      total_q         <= '0;
      rd_cnt_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      start_err_q     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_c) begin
        total_q  <= CW'(bs_subtile_K) * CW'(bs_subtile_HW);
        rd_cnt_q <= '0;
      end else if (rd_c) begin
        rd_cnt_q <= rd_cnt_q + CW'(1);
      end
      inflight_q      <= rd_c;
      inflight_last_q <= rd_c && last_rd_c;
      if (inflight_q) wr_ptr_q <= ~wr_ptr_q;
      if (pop_c) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + 2'(inflight_q) - 2'(pop_c);
      if (bs_wb_tile_start && (state != IDLE)) start_err_q <= 1'b1;
    end
  end

  // FIFO storage; contents are meaningless whenever count_q says so
  always_ff @(posedge clk) begin
    if (inflight_q) fifo_q[wr_ptr_q] <= {inflight_last_q, bs_out_buf_wb_data};
  end

  assign bs_out_buf_wb_rd   = rd_c;
  assign bs_out_buf_wb_addr = rd_c ? BS_OUT_BUF_DEPTH'(rd_cnt_q) : '0;
  assign m_valid            = (count_q != 2'd0);
  assign m_data             = m_valid ? head_c.data : '0;
  assign m_last             = m_valid && head_c.last;
  assign bs_wb_busy         = (state != IDLE);
  assign bs_wb_tile_end     = (state == DONE);
  assign bs_wb_start_err    = start_err_q;

endmodule

// File: tb/tb_lut_out_drain.sv
// Scoreboard bench for lut_out_drain: driver queues expected words per tile, monitor checks the stream.
module tb_lut_out_drain;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    k_in;
  logic [7:0]    hw_in;
  logic [AW-1:0] addr;
  logic          rd;
  logic [DW-1:0] rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;
  logic          busy;
  logic          tile_end;
  logic          start_err;

  lut_out_drain #(.BS_OUT_BUF_DEPTH(AW), .OUT_DATA_W(DW)) dut (
    .clk                (clk),
    .rst                (rst),
    .bs_wb_tile_start   (start),
    .bs_subtile_K       (k_in),
    .bs_subtile_HW      (hw_in),
    .bs_out_buf_wb_addr (addr),
    .bs_out_buf_wb_rd   (rd),
    .bs_out_buf_wb_data (rdata),
    .m_data             (m_data),
    .m_valid            (m_valid),
    .m_last             (m_last),
    .m_ready            (m_ready),
    .bs_wb_busy         (busy),
    .bs_wb_tile_end     (tile_end),
    .bs_wb_start_err    (start_err)
  );

  always #5 clk = ~clk;

  int unsigned   n_cmp = 0;
  int unsigned   n_fail = 0;
  logic [31:0]   seed = 32'h5a17_c3e1;
  logic [DW:0]   exp_q[$];
  longint        rd_cyc_q[$];
  int unsigned   rd_addr_q[$];
  longint        cyc = 0;
  longint        start_cyc = 0;
  int unsigned   rd_count = 0;
  int unsigned   pop_count = 0;
  int unsigned   zero_starts = 0;
  int unsigned   zero_seen = 0;
  logic          te_due = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_w(input string nm, input logic [DW:0] act, input logic [DW:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Buffer content is a fixed hash of the address
  function automatic logic [DW-1:0] word_of(input int unsigned a);
    logic [DW-1:0] w;
    for (int i = 0; i < int'(DW / 32); i++)
      w[i*32 +: 32] = (a * 32'h9E3779B1) ^ (32'(i) * 32'h01010101) ^ seed;
    return w;
  endfunction

  // Output buffer model with 1-cycle read latency; also logs every read
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd) rdata <= word_of(32'(addr));
    else    rdata <= {16{$urandom}};
    if (rst) rd_count <= 0;
    else if (rd) begin
      rd_count <= rd_count + 1;
      rd_cyc_q.push_back(cyc);
      rd_addr_q.push_back(32'(addr));
    end
  end

  // Monitor: stream scoreboard, stall stability, occupancy bound, tile_end timing
  always @(negedge clk) begin
    logic        te_n;
    logic [DW:0] e;
    if (rst) begin
      exp_q.delete();
      pop_count  = 0;
      te_due     = 1'b0;
      prev_stall = 1'b0;
      zero_seen  = zero_starts;
    end else begin
      te_n = 1'b0;
      if (te_due || tile_end) chk("tile_end", 64'(tile_end), 64'(te_due));
      if (zero_starts != zero_seen) begin
        te_n      = 1'b1;
        zero_seen = zero_starts;
      end
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 1);
        chk_w("stall_hold", {m_last, m_data}, {prev_last, prev_data});
      end
      if (m_valid) chk("occupancy_over_2", 64'((rd_count - pop_count) > 2), 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got last=%0d with empty scoreboard", m_last);
        end else begin
          e = exp_q.pop_front();
          chk_w("word", {m_last, m_data}, e);
          if (e[DW]) te_n = 1'b1;
        end
        pop_count++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      te_due     = te_n;
    end
  end

  task automatic start_tile(input int unsigned k, input int unsigned hw, output bit acc);
    @(posedge clk); #1;
    k_in      = 8'(k);
    hw_in     = 8'(hw);
    start     = 1'b1;
    start_cyc = cyc;
    acc       = !busy;
    if (acc) begin
      if (k == 0 || hw == 0) zero_starts++;
      else
        for (int kk = 0; kk < int'(k); kk++)
          for (int hh = 0; hh < int'(hw); hh++)
            exp_q.push_back({1'b1 && (kk == int'(k) - 1) && (hh == int'(hw) - 1),
                             word_of((32'(kk) * hw + 32'(hh)) & 32'hFFFF)});
    end
    @(posedge clk); #1;
    start = 1'b0;
    k_in  = 8'($urandom);
    hw_in = 8'($urandom);
  endtask

  // mode 0: ready held high, 1: toggle, 2: random
  task automatic wait_idle(input int mode, input int bound);
    int n = 0;
    while (busy && n < bound) begin
      @(posedge clk); #1;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      n++;
    end
    chk("wait_idle_busy", 64'(busy), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_valid"}, 64'(m_valid), 0);
    chk({nm, "_last"}, 64'(m_last), 0);
    chk({nm, "_data_nz"}, 64'(m_data != '0), 0);
    chk({nm, "_busy"}, 64'(busy), 0);
    chk({nm, "_tile_end"}, 64'(tile_end), 0);
    chk({nm, "_rd"}, 64'(rd), 0);
    chk({nm, "_addr"}, 64'(addr), 0);
    chk({nm, "_start_err"}, 64'(start_err), 0);
  endtask

  initial begin
    bit acc;
    int unsigned base;
    int n;
    rst = 1'b1; start = 1'b0; k_in = '0; hw_in = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // K=2,HW=3 at full rate: address order, read timing, busy length
    m_ready = 1'b1;
    base = rd_addr_q.size();
    start_tile(2, 3, acc);
    chk("t1_accepted", 64'(acc), 1);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t1_busy_cycles", 64'(n), 9);
    chk("t1_reads", 64'(rd_addr_q.size() - base), 6);
    for (int i = 0; i < 6 && base + i < rd_addr_q.size(); i++) begin
      chk("t1_addr", 64'(rd_addr_q[base + i]), 64'(i));
      chk("t1_rd_cycle", 64'(rd_cyc_q[base + i] - start_cyc), 64'(1 + i));
    end

    // K=1,HW=4 with the sink stalled after first valid
    m_ready = 1'b0;
    base = rd_addr_q.size();
    start_tile(1, 4, acc);
    n = 0;
    while (!m_valid && n < 20) begin
      n++;
      @(posedge clk); #1;
    end
    chk("t2_first_valid", 64'(m_valid), 1);
    repeat (5) @(posedge clk);
    #1;
    chk("t2_reads_while_stalled", 64'(rd_addr_q.size() - base), 2);
    wait_idle(0, 100);

    // K=3,HW=3 with ready toggling every cycle
    start_tile(3, 3, acc);
    wait_idle(1, 200);

    // Zero-size tiles: no reads, tile_end only
    base = rd_addr_q.size();
    start_tile(0, 5, acc);
    wait_idle(0, 10);
    start_tile(7, 0, acc);
    wait_idle(0, 10);
    chk("t4_no_reads", 64'(rd_addr_q.size() - base), 0);

    // Second start mid-tile is ignored and flagged
    chk("t5_err_before", 64'(start_err), 0);
    start_tile(3, 3, acc);
    repeat (3) @(posedge clk);
    start_tile(4, 4, acc);
    chk("t5_second_accepted", 64'(acc), 0);
    chk("t5_err_set", 64'(start_err), 1);
    wait_idle(2, 500);
    chk("t5_err_sticky", 64'(start_err), 1);

    // Randomized tiles under random backpressure
    for (int t = 0; t < 10; t++) begin
      start_tile($urandom_range(0, 6), $urandom_range(1, 6), acc);
      wait_idle(2, 1000);
    end

    // Reset mid-FLUSH with a word presented, then a full-size tile
    m_ready = 1'b0;
    start_tile(1, 2, acc);
    repeat (4) @(posedge clk);
    #1;
    chk("t6_valid_before_rst", 64'(m_valid), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("t6_after_rst");
    rst = 1'b0;
    m_ready = 1'b1;
    base = rd_addr_q.size();
    start_tile(255, 255, acc);
    wait_idle(0, 70000);
    chk("t6_reads", 64'(rd_addr_q.size() - base), 65025);
    if (rd_addr_q.size() > 0) chk("t6_last_addr", 64'(rd_addr_q[rd_addr_q.size() - 1]), 65024);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
